// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer: state encoding, digit width, digit maxima.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam int unsigned DigitW        = 4;
   localparam int unsigned UnitsMax      = 9;
   localparam int unsigned MinTensMaxDef = 9;
   localparam int unsigned SecTensMaxDef = 5;

   function automatic logic [DigitW-1:0] clamp_digit(input logic [DigitW-1:0] d,
                                                     input int unsigned        max);
      logic [DigitW-1:0] m;
      m = DigitW'(max);
      return (d > m) ? m : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with clamped synchronous load; steps when dec and borrow_in are high.
module bcd_down_digit
   import countdown_timer_pkg::*;
#(
   parameter int unsigned MAX = 9
) (
   input  logic              clk,
   input  logic              res,
   input  logic              load,
   input  logic [DigitW-1:0] load_val,
   input  logic              dec,
   input  logic              borrow_in,
   output logic              borrow_out,
   output logic [DigitW-1:0] value
);

   localparam logic [DigitW-1:0] MaxV = DigitW'(MAX);

   logic [DigitW-1:0] value_q;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= clamp_digit(load_val, MAX);
      end else if (dec && borrow_in) begin
         value_q <= (value_q == '0) ? MaxV : value_q - 1'b1;
      end
   end

   // borrow_in of the units digit is tied high, so the chain end also flags "all digits zero".
   assign borrow_out = borrow_in && (value_q == '0);
   assign value      = value_q;

endmodule

// File: rtl/countdown_timer.sv
// Settable MM:SS BCD countdown timer with start/pause toggle and one-cycle done pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value on expiry.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned MIN_TENS_MAX = MinTensMaxDef,
   parameter int unsigned SEC_TENS_MAX = SecTensMaxDef
) (
   input  logic        clk,
   input  logic        res,
   input  logic        ena,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        start,
   output logic [3:0]  cnt_s0,
   output logic [3:0]  cnt_s1,
   output logic [3:0]  cnt_m0,
   output logic [3:0]  cnt_m1,
   output logic        running,
   output logic        done
);

   state_e      state_q, state_d;
   logic        done_q, done_d;
   logic        running_q, running_d;
   logic        tick;
   logic        reload;
   logic        digit_load;
   logic [15:0] digit_val;
   logic [4:0]  borrow;
   logic        is_zero;
   logic        is_one;

   assign borrow[0] = 1'b1;
   assign is_zero   = borrow[4];
   assign is_one    = (cnt_s0 == 4'd1) && (cnt_s1 == '0) && (cnt_m0 == '0) && (cnt_m1 == '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [15:0] reload_q;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         reload_q <= '0;
      end else if (load) begin
         reload_q <= {clamp_digit(load_val[15:12], MIN_TENS_MAX),
                      clamp_digit(load_val[11:8], UnitsMax),
                      clamp_digit(load_val[7:4], SEC_TENS_MAX),
                      clamp_digit(load_val[3:0], UnitsMax)};
      end
   end

   assign digit_val = load ? load_val : reload_q;
`else
   assign digit_val = load_val;
`endif

   assign digit_load = load || reload;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      tick    = 1'b0;
      reload  = 1'b0;
      if (load) begin
         state_d = StIdle;
      end else if (start) begin
         unique case (state_q)
            StIdle, StPause: if (!is_zero) state_d = StRun;
            StRun:           state_d = StPause;
            default:         state_d = state_q;
         endcase
      end else if (ena && (state_q == StRun)) begin
         if (is_one) begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload = 1'b1;
`else
            tick    = 1'b1;
            state_d = StDone;
`endif
         end else begin
            tick = 1'b1;
         end
      end
      running_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q   <= StIdle;
         done_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         running_q <= running_d;
      end
   end

   assign done    = done_q;
   assign running = running_q;

   bcd_down_digit #(.MAX(UnitsMax)) u_s0 (
      .clk        (clk),
      .res        (res),
      .load       (digit_load),
      .load_val   (digit_val[3:0]),
      .dec        (tick),
      .borrow_in  (borrow[0]),
      .borrow_out (borrow[1]),
      .value      (cnt_s0)
   );

   bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_s1 (
      .clk        (clk),
      .res        (res),
      .load       (digit_load),
      .load_val   (digit_val[7:4]),
      .dec        (tick),
      .borrow_in  (borrow[1]),
      .borrow_out (borrow[2]),
      .value      (cnt_s1)
   );

   bcd_down_digit #(.MAX(UnitsMax)) u_m0 (
      .clk        (clk),
      .res        (res),
      .load       (digit_load),
      .load_val   (digit_val[11:8]),
      .dec        (tick),
      .borrow_in  (borrow[2]),
      .borrow_out (borrow[3]),
      .value      (cnt_m0)
   );

   bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_m1 (
      .clk        (clk),
      .res        (res),
      .load       (digit_load),
      .load_val   (digit_val[15:12]),
      .dec        (tick),
      .borrow_in  (borrow[3]),
      .borrow_out (borrow[4]),
      .value      (cnt_m1)
   );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; expected values are hand-computed BCD times.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        res;
   logic        ena;
   logic        load;
   logic [15:0] load_val;
   logic        start;
   logic [3:0]  cnt_s0, cnt_s1, cnt_m0, cnt_m1;
   logic        running;
   logic        done;

   int total = 0;
   int bad   = 0;

   countdown_timer dut (
      .clk      (clk),
      .res      (res),
      .ena      (ena),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .cnt_s0   (cnt_s0),
      .cnt_s1   (cnt_s1),
      .cnt_m0   (cnt_m0),
      .cnt_m1   (cnt_m1),
      .running  (running),
      .done     (done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] shown();
      return {cnt_m1, cnt_m0, cnt_s1, cnt_s0};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      load     = 1'b1;
      load_val = v;
      step();
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      res = 1'b0; ena = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
      #12;
      check("rst_val", shown(), 16'h0000);
      check("rst_run", 16'(running), 16'h0);
      check("rst_done", 16'(done), 16'h0);
      res = 1'b1;
      step();

      // 01:05 counts down through the minute boundary
      do_load(16'h0105);
      check("t1_load", shown(), 16'h0105);
      check("t1_idle", 16'(running), 16'h0);
      pulse_start();
      check("t1_run", 16'(running), 16'h1);
      ena = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t1_run_hold", 16'(running), 16'h1);
      end
      check("t1_0100", shown(), 16'h0100);
      step();
      ena = 1'b0;
      check("t1_0059", shown(), 16'h0059);
      check("t1_run_end", 16'(running), 16'h1);

      // start with zero value is ignored
      do_load(16'h0000);
      pulse_start();
      check("zero_start", 16'(running), 16'h0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
      // expiry: done for exactly one cycle, then DONE holds
      do_load(16'h0002);
      pulse_start();
      ena = 1'b1;
      step();
      check("t2_0001", shown(), 16'h0001);
      check("t2_nodone", 16'(done), 16'h0);
      step();
      check("t2_0000", shown(), 16'h0000);
      check("t2_done", 16'(done), 16'h1);
      check("t2_stop", 16'(running), 16'h0);
      step();
      check("t2_done_off", 16'(done), 16'h0);
      check("t2_hold", shown(), 16'h0000);
      start = 1'b1;
      step();
      start = 1'b0;
      ena   = 1'b0;
      check("t2_start_ign", 16'(running), 16'h0);
      check("t2_hold2", shown(), 16'h0000);
      check("t2_done_off2", 16'(done), 16'h0);
`else
      // auto reload: period equals loaded value
      do_load(16'h0003);
      pulse_start();
      ena = 1'b1;
      step();
      step();
      check("t6_0001", shown(), 16'h0001);
      step();
      check("t6_done1", 16'(done), 16'h1);
      check("t6_reload", shown(), 16'h0003);
      check("t6_run", 16'(running), 16'h1);
      step();
      check("t6_done_off", 16'(done), 16'h0);
      check("t6_0002", shown(), 16'h0002);
      step();
      step();
      ena = 1'b0;
      check("t6_done2", 16'(done), 16'h1);
      check("t6_reload2", shown(), 16'h0003);
`endif

      // start and ena together in RUN: pause wins
      do_load(16'h0031);
      pulse_start();
      ena = 1'b1;
      step();
      check("t3_0030", shown(), 16'h0030);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t3_pause", 16'(running), 16'h0);
      check("t3_pause_val", shown(), 16'h0030);
      repeat (3) step();
      ena = 1'b0;
      check("t3_pause_hold", shown(), 16'h0030);
      pulse_start();
      check("t3_resume", 16'(running), 16'h1);
      ena = 1'b1;
      step();
      ena = 1'b0;
      check("t3_0029", shown(), 16'h0029);

      // clamp on load, then load mid-run wins over ena
      do_load(16'h9F9F);
      check("t4_clamp", shown(), 16'h9959);
      pulse_start();
      ena = 1'b1;
      step();
      check("t4_9958", shown(), 16'h9958);
      do_load(16'h0010);
      ena = 1'b0;
      check("t4_reload", shown(), 16'h0010);
      check("t4_idle", 16'(running), 16'h0);

      // borrow through every digit
      do_load(16'h1000);
      pulse_start();
      ena = 1'b1;
      step();
      ena = 1'b0;
      check("borrow_0959", shown(), 16'h0959);

      // asynchronous reset mid-run
      do_load(16'h1234);
      pulse_start();
      check("t5_run", 16'(running), 16'h1);
      #2;
      res = 1'b0;
      #1;
      check("t5_val", shown(), 16'h0000);
      check("t5_run_off", 16'(running), 16'h0);
      check("t5_done", 16'(done), 16'h0);
      res = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
